// File: rtl/lcd_reg_display.sv
// Snapshots NUM_REGS registers on a capture/refresh trigger and streams a labelled
// hex dump ("L:HHHH ") to an LCD controller, one character per write handshake.
module lcd_reg_display #(
  parameter int                    NUM_REGS       = 4,
  parameter int                    DATA_W         = 8,
  parameter logic [NUM_REGS*8-1:0] LABELS         = "AXYO",
  parameter logic [23:0]           REFRESH_CYCLES = 24'd10_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REGS*DATA_W-1:0] regs_in,
  input  logic                       capture,
  input  logic                       mode,
  input  logic                       initDone,
  input  logic                       writeDone,
  output logic [7:0]                 data,
  output logic                       writeStart,
  output logic                       clrLCD,
  output logic                       busy,
  output logic                       overrun
);
  localparam int NDIG   = DATA_W / 4;
  localparam int CH_LEN = NDIG + 3;

  typedef enum logic [2:0] {WAIT_INIT, IDLE, CLEAR, CLR_WAIT, EMIT, EMIT_WAIT} state_t;

  state_t                     state_reg, state_next;
  logic                       capture_q_reg, pending_reg, overrun_reg;
  logic [23:0]                refresh_cnt_reg;
  logic [NUM_REGS*DATA_W-1:0] snap_reg;
  logic [3:0]                 ch_reg;
  logic [2:0]                 pos_reg;
  logic [5:0]                 vc_reg;
  logic                       nl_done_reg;
  logic [7:0]                 data_reg;
  logic                       write_start_reg, clr_lcd_reg;

  logic              cap_edge, refresh_tick, trigger, take_snap;
  logic [DATA_W-1:0] word_arr [NUM_REGS];
  logic [7:0]        label_arr [NUM_REGS];
  logic [DATA_W-1:0] cur_word;
  logic [7:0]        cur_label, vis_char, cur_item;
  logic [3:0]        cur_nib;
  logic              is_nl, pos_last, seq_end, dump_done;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_chan
      assign word_arr[gi]  = snap_reg[DATA_W*(NUM_REGS-gi)-1 -: DATA_W];
      assign label_arr[gi] = LABELS[8*(NUM_REGS-gi)-1 -: 8];
    end
  endgenerate

  assign cap_edge     = capture & ~capture_q_reg;
  assign refresh_tick = mode && (refresh_cnt_reg == REFRESH_CYCLES - 24'd1);
  assign trigger      = cap_edge | refresh_tick;
  assign take_snap    = (state_reg == IDLE) && pending_reg;

  always_comb begin
    cur_word  = '0;
    cur_label = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ch_reg == 4'(i)) begin
        cur_word  = word_arr[i];
        cur_label = label_arr[i];
      end
    end
    cur_nib = 4'h0;
    for (int d = 0; d < NDIG; d++) begin
      if (pos_reg == 3'(d + 2)) cur_nib = cur_word[4*(NDIG-d)-1 -: 4];
    end
  end

  // Channel item layout: label, ':', hex digits MS first, ' '
  always_comb begin
    if (pos_reg == 3'd0)                vis_char = cur_label;
    else if (pos_reg == 3'd1)           vis_char = 8'h3A;
    else if (pos_reg == 3'(CH_LEN - 1)) vis_char = 8'h20;
    else if (cur_nib < 4'd10)           vis_char = 8'h30 + {4'h0, cur_nib};
    else                                vis_char = 8'h37 + {4'h0, cur_nib};
  end

  assign is_nl     = (vc_reg == 6'd16) && !nl_done_reg;
  assign cur_item  = is_nl ? 8'h0A : vis_char;
  assign pos_last  = (pos_reg == 3'(CH_LEN - 1));
  assign seq_end   = pos_last && (ch_reg == 4'(NUM_REGS - 1));
  assign dump_done = !is_nl && (seq_end || (vc_reg == 6'd31));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_INIT: if (initDone) state_next = IDLE;
      IDLE:      if (pending_reg) state_next = CLEAR;
      CLEAR:     state_next = CLR_WAIT;
      CLR_WAIT:  if (writeDone) state_next = EMIT;
      EMIT:      state_next = EMIT_WAIT;
      EMIT_WAIT: if (writeDone) state_next = dump_done ? IDLE : EMIT;
      default:   state_next = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= WAIT_INIT;
      capture_q_reg   <= 1'b0;
      pending_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      refresh_cnt_reg <= '0;
      snap_reg        <= '0;
      ch_reg          <= '0;
      pos_reg         <= '0;
      vc_reg          <= '0;
      nl_done_reg     <= 1'b0;
      data_reg        <= 8'h00;
      write_start_reg <= 1'b0;
      clr_lcd_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      capture_q_reg <= capture;
      if (!mode || refresh_tick) refresh_cnt_reg <= '0;
      else                       refresh_cnt_reg <= refresh_cnt_reg + 24'd1;
      // A new trigger wins over the IDLE consume so it is never lost
      if (trigger && pending_reg) overrun_reg <= 1'b1;
      if (trigger)        pending_reg <= 1'b1;
      else if (take_snap) pending_reg <= 1'b0;
      if (take_snap) snap_reg <= regs_in;
      clr_lcd_reg     <= (state_reg == CLEAR);
      write_start_reg <= (state_reg == EMIT);
      if (state_reg == EMIT) data_reg <= cur_item;
      if (state_reg == CLR_WAIT && writeDone) begin
        ch_reg      <= '0;
        pos_reg     <= '0;
        vc_reg      <= '0;
        nl_done_reg <= 1'b0;
      end else if (state_reg == EMIT_WAIT && writeDone) begin
        if (is_nl) begin
          nl_done_reg <= 1'b1;
        end else begin
          vc_reg <= vc_reg + 6'd1;
          if (pos_last) begin
            pos_reg <= '0;
            ch_reg  <= ch_reg + 4'd1;
          end else begin
            pos_reg <= pos_reg + 3'd1;
          end
        end
      end
    end
  end

  assign data       = data_reg;
  assign writeStart = write_start_reg;
  assign clrLCD     = clr_lcd_reg;
  assign busy       = (state_reg != WAIT_INIT) && (state_reg != IDLE);
  assign overrun    = overrun_reg;
endmodule

// File: tb/tb_lcd_reg_display.sv
// Bench for lcd_reg_display: a 4x8 instance (fast refresh) and an 8x16 instance
// (truncation, mid-dump reset), checked against a string-level dump model.
module tb_lcd_reg_display;
  localparam int          NA    = 4;
  localparam int          WA    = 8;
  localparam int          NB    = 8;
  localparam int          WB    = 16;
  localparam logic [31:0] LAB_A = "AXYO";
  localparam logic [63:0] LAB_B = "ABCDEFGH";

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, capture_a, mode_a, init_a, wd_a;
  logic [NA*WA-1:0] regs_a;
  logic [7:0]       data_a;
  logic             ws_a, clr_a, busy_a, ovr_a;
  logic             rst_b, capture_b, mode_b, init_b, wd_b;
  logic [NB*WB-1:0] regs_b;
  logic [7:0]       data_b;
  logic             ws_b, clr_b, busy_b, ovr_b;

  lcd_reg_display #(.NUM_REGS(NA), .DATA_W(WA), .LABELS(LAB_A), .REFRESH_CYCLES(24'd200)) dut_a (
    .clk(clk), .rst(rst_a), .regs_in(regs_a), .capture(capture_a), .mode(mode_a),
    .initDone(init_a), .writeDone(wd_a), .data(data_a), .writeStart(ws_a),
    .clrLCD(clr_a), .busy(busy_a), .overrun(ovr_a));

  lcd_reg_display #(.NUM_REGS(NB), .DATA_W(WB), .LABELS(LAB_B)) dut_b (
    .clk(clk), .rst(rst_b), .regs_in(regs_b), .capture(capture_b), .mode(mode_b),
    .initDone(init_b), .writeDone(wd_b), .data(data_b), .writeStart(ws_b),
    .clrLCD(clr_b), .busy(busy_b), .overrun(ovr_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wd_a = -1;
  int proto_viol = 0;
  int delay_a = 2;
  logic prev_ws_a = 1'b0, prev_clr_a = 1'b0, in_wait_a = 1'b0;
  logic [7:0] held_a = 8'h00;
  logic [8:0] log_a[$];
  logic [8:0] log_b[$];
  logic [8:0] exp_q[$];
  int clr_cyc_a[$];

  typedef struct packed {
    logic [31:0]  regs;
    logic [167:0] text;
  } vec_t;
  vec_t tbl [5];

  // Monitor: logs items (9'h100 = clear) and counts handshake-rule violations
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_a) begin
        last_wd_a = -1;
        in_wait_a = 1'b0;
      end else begin
        if (ws_a && clr_a) proto_viol++;
        if (ws_a && prev_ws_a) proto_viol++;
        if (clr_a && prev_clr_a) proto_viol++;
        if (in_wait_a && data_a !== held_a) proto_viol++;
        if (wd_a) begin
          in_wait_a = 1'b0;
          last_wd_a = cyc;
        end
        if (clr_a) begin
          log_a.push_back(9'h100);
          clr_cyc_a.push_back(cyc);
        end
        if (ws_a) begin
          log_a.push_back({1'b0, data_a});
          if (last_wd_a < 0 || cyc - last_wd_a != 2) proto_viol++;
          in_wait_a = 1'b1;
          held_a    = data_a;
        end
      end
      prev_ws_a  = ws_a;
      prev_clr_a = clr_a;
      if (clr_b) log_b.push_back(9'h100);
      if (ws_b)  log_b.push_back({1'b0, data_b});
    end
  end

  initial begin
    wd_a = 1'b0;
    forever begin
      @(negedge clk);
      if (ws_a || clr_a) begin
        repeat (delay_a) @(posedge clk);
        #1 wd_a = 1'b1;
        @(posedge clk);
        #1 wd_a = 1'b0;
      end
    end
  end

  initial begin
    wd_b = 1'b0;
    forever begin
      @(negedge clk);
      if (ws_b || clr_b) begin
        @(posedge clk);
        #1 wd_b = 1'b1;
        @(posedge clk);
        #1 wd_b = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference dump: build the full visible text, keep 32 chars, newline before the 17th
  function automatic void model_dump(input logic [127:0] regs, input int n, input int w,
                                     input logic [63:0] labels);
    logic [7:0]   vis[$];
    logic [127:0] word;
    logic [3:0]   nib;
    exp_q.push_back(9'h100);
    for (int ch = 0; ch < n; ch++) begin
      word = (regs >> (w * (n - 1 - ch))) & ((128'd1 << w) - 128'd1);
      vis.push_back(labels[8*(n-1-ch) +: 8]);
      vis.push_back(8'h3A);
      for (int d = w / 4 - 1; d >= 0; d--) begin
        nib = 4'((word >> (4 * d)) & 128'hF);
        vis.push_back(nib < 4'd10 ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10);
      end
      vis.push_back(8'h20);
    end
    for (int i = 0; i < vis.size() && i < 32; i++) begin
      if (i == 16) exp_q.push_back(9'h00A);
      exp_q.push_back({1'b0, vis[i]});
    end
  endfunction

  task automatic table_dump(input int k);
    exp_q.push_back(9'h100);
    for (int i = 20; i >= 0; i--) exp_q.push_back({1'b0, tbl[k].text[8*i +: 8]});
  endtask

  task automatic chk_log(input bit sel_b, input string name);
    logic [8:0] got[$];
    int bad = -1;
    int lim;
    if (sel_b) got = log_b;
    else       got = log_a;
    lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0 || got.size() != exp_q.size()) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s item %0d actual=%h required=%h (items %0d vs %0d)",
                 name, bad, got[bad], exp_q[bad], got.size(), exp_q.size());
      else
        $display("FAIL %s item count actual=%0d required=%0d", name, got.size(), exp_q.size());
    end
    $display("dump %s items=%0d expected=%0d", name, got.size(), exp_q.size());
  endtask

  task automatic pulse(input bit sel_b);
    @(negedge clk);
    if (sel_b) capture_b = 1'b1; else capture_a = 1'b1;
    repeat (3) @(negedge clk);
    capture_a = 1'b0;
    capture_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_quiet(input bit sel_b, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 10 && n < budget) begin
      @(negedge clk);
      n++;
      if ((sel_b ? busy_b : busy_a) == 1'b0) quiet++;
      else quiet = 0;
    end
    if (quiet < 10) begin
      checks++;
      errors++;
      $display("FAIL wait_quiet busy actual=1 required=0 after %0d cycles", budget);
    end
  endtask

  task automatic wait_log(input bit sel_b, input int target, input int budget);
    int k = 0;
    while ((sel_b ? log_b.size() : log_a.size()) < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_log items actual<%0d required=%0d", target, target);
    end
  endtask

  initial begin
    int n_clr;
    int n_log;
    tbl[0] = {32'h3C01FFA9, "A:3C X:01 Y:FF O\n:A9 "};
    tbl[1] = {32'h00000000, "A:00 X:00 Y:00 O\n:00 "};
    tbl[2] = {32'h12345678, "A:12 X:34 Y:56 O\n:78 "};
    tbl[3] = {32'hDEADBEEF, "A:DE X:AD Y:BE O\n:EF "};
    tbl[4] = {32'h9A0FF0B5, "A:9A X:0F Y:F0 O\n:B5 "};

    rst_a = 1'b1; capture_a = 1'b0; mode_a = 1'b0; init_a = 1'b0; regs_a = '0;
    rst_b = 1'b1; capture_b = 1'b0; mode_b = 1'b0; init_b = 1'b1; regs_b = '0;
    repeat (2) @(negedge clk);
    capture_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_ws", 32'(ws_a), 0);
    chk("rst_clr", 32'(clr_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_ovr", 32'(ovr_a), 0);
    capture_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Capture while the controller is not initialised: held until initDone
    regs_a = 32'h3C01FFA9;
    pulse(1'b0);
    repeat (100) @(negedge clk);
    #1;
    chk("init_hold_items", log_a.size(), 0);
    chk("init_hold_busy", 32'(busy_a), 0);
    init_a = 1'b1;
    wait_quiet(1'b0, 500);
    exp_q.delete();
    table_dump(0);
    chk_log(1'b0, "after_init");
    log_a.delete();

    // Cycle-exact capture -> clear -> final writeDone -> busy fall
    @(negedge clk); capture_a = 1'b1;
    @(negedge clk); chk("edge_busy_t1", 32'(busy_a), 0);
    @(negedge clk); chk("edge_busy_t2", 32'(busy_a), 1); chk("edge_clr_t2", 32'(clr_a), 0);
    @(negedge clk); chk("edge_clr_t3", 32'(clr_a), 1); chk("edge_ws_t3", 32'(ws_a), 0);
    @(negedge clk); chk("edge_clr_t4", 32'(clr_a), 0);
    capture_a = 1'b0;
    wait_log(1'b0, 22, 500);
    @(negedge clk); chk("tail_busy_1", 32'(busy_a), 1);
    @(negedge clk); chk("tail_busy_2", 32'(busy_a), 1);
    @(negedge clk); chk("tail_busy_3", 32'(busy_a), 0);
    wait_quiet(1'b0, 200);
    exp_q.delete();
    table_dump(0);
    chk_log(1'b0, "edge_timing");
    log_a.delete();

    for (int k = 0; k < 5; k++) begin
      regs_a = tbl[k].regs;
      pulse(1'b0);
      wait_quiet(1'b0, 1000);
      exp_q.delete();
      table_dump(k);
      chk_log(1'b0, $sformatf("table%0d", k));
      log_a.delete();
    end

    // Inputs change mid-dump; snapshot must hold
    regs_a = 32'h3C01FFA9;
    pulse(1'b0);
    wait_log(1'b0, 11, 500);
    regs_a = '0;
    wait_quiet(1'b0, 1000);
    exp_q.delete();
    table_dump(0);
    chk_log(1'b0, "frozen_snapshot");
    log_a.delete();

    for (int k = 0; k < 12; k++) begin
      regs_a  = $urandom;
      delay_a = $urandom_range(1, 4);
      pulse(1'b0);
      wait_quiet(1'b0, 2000);
      exp_q.delete();
      model_dump(128'(regs_a), NA, WA, 64'(LAB_A));
      chk_log(1'b0, $sformatf("rand%0d_%h", k, regs_a));
      log_a.delete();
    end
    delay_a = 2;
    chk("no_overrun_yet", 32'(ovr_a), 0);

    // Continuous refresh: exactly 5 dumps 200 cycles apart, then none in mode 0
    clr_cyc_a.delete();
    @(negedge clk); mode_a = 1'b1;
    repeat (1050) @(negedge clk);
    mode_a = 1'b0;
    wait_quiet(1'b0, 1000);
    n_clr = clr_cyc_a.size();
    chk("refresh_count", n_clr, 5);
    for (int i = 1; i < n_clr; i++)
      chk($sformatf("refresh_gap%0d", i), clr_cyc_a[i] - clr_cyc_a[i-1], 200);
    chk("refresh_items", log_a.size(), 5 * 22);
    repeat (600) @(negedge clk);
    #1;
    chk("mode0_no_dump", clr_cyc_a.size(), 5);
    chk("mode_no_overrun", 32'(ovr_a), 0);
    log_a.delete();

    // Two captures during one dump -> overrun and exactly one extra dump
    regs_a = 32'h12345678;
    pulse(1'b0);
    wait_log(1'b0, 6, 500);
    chk("ovr_before", 32'(ovr_a), 0);
    pulse(1'b0);
    pulse(1'b0);
    wait_quiet(1'b0, 2000);
    chk("ovr_set", 32'(ovr_a), 1);
    exp_q.delete();
    table_dump(2);
    table_dump(2);
    chk_log(1'b0, "overrun_two_dumps");
    log_a.delete();
    pulse(1'b0);
    wait_quiet(1'b0, 1000);
    chk("ovr_sticky", 32'(ovr_a), 1);
    chk("protocol_viol", proto_viol, 0);

    // Wide instance: truncation to 32 visible chars plus one newline
    regs_b = {$urandom, $urandom, $urandom, $urandom};
    pulse(1'b1);
    wait_quiet(1'b1, 3000);
    exp_q.delete();
    model_dump(regs_b, NB, WB, LAB_B);
    chk_log(1'b1, "trunc_8x16");
    chk("trunc_items", log_b.size(), 34);
    chk("trunc_nl_pos", 32'(log_b[17]), 32'h00A);
    log_b.delete();

    // Reset mid-dump aborts with no further pulses
    pulse(1'b1);
    wait_log(1'b1, 8, 500);
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk);
    chk("midrst_data", 32'(data_b), 0);
    chk("midrst_ws", 32'(ws_b), 0);
    chk("midrst_clr", 32'(clr_b), 0);
    chk("midrst_busy", 32'(busy_b), 0);
    chk("midrst_ovr", 32'(ovr_b), 0);
    rst_b = 1'b0;
    #1;
    n_log = log_b.size();
    repeat (60) @(negedge clk);
    #1;
    chk("midrst_quiet", log_b.size(), n_log);
    chk("midrst_idle_busy", 32'(busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
